instruction_loader: RTL
=======================

Name: instruction_loader

Overview:
- Writer side of the instruction-memory interface that the ID stage decodes from.
- Assembles a byte stream from the debug UART receiver into 32-bit MIPS instruction words and writes them sequentially into instruction memory from word address 0.
- The session ends on the HALT word, which is itself written, or on memory overflow.
- Status outputs tell the debug unit when the pipeline may be released.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width (depth 2^ADDR_WIDTH words).
- HALT_WORD, 32'hFFFFFFFF, instruction word that terminates a load session.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout. Used only with the optional feature; must be at least 2.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous active-low reset (0 = reset).
- i_start  input  1  one-cycle pulse; starts or restarts a load session.
- i_rx_byte  input  8  received byte; valid only when i_rx_valid=1.
- i_rx_valid  input  1  one-cycle strobe per received byte.
- o_imem_wr_en  output  1  instruction-memory write enable, one cycle per word.
- o_imem_wr_addr  output  ADDR_WIDTH  word address of the write.
- o_imem_wr_data  output  32  instruction word to write.
- o_busy  output  1  session active (COLLECT or WRITE).
- o_done  output  1  HALT word written; held until the next i_start.
- o_error  output  1  overflow (or timeout); held until the next i_start.
- o_word_count  output  ADDR_WIDTH+1  words written in the current session, HALT word included.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all outputs 0; byte counter, shift register, address and count all 0. Reset asserted mid-session aborts it immediately; no partial write is issued.
- All outputs are registered.
- Byte order is big-endian: first byte goes to [31:24], fourth byte to [7:0]. Shift register update: word <= {word[23:0], i_rx_byte}.
- State IDLE: i_rx_valid is ignored. i_start -> COLLECT with byte_cnt=0, addr=0, word_count=0.
- State COLLECT: each i_rx_valid shifts in one byte and increments byte_cnt (0..3). On the strobe that completes byte 4, byte_cnt wraps to 0 and the next state is WRITE.
- State WRITE (exactly one cycle):
  - o_imem_wr_en=1, o_imem_wr_addr=addr, o_imem_wr_data=assembled word; word_count increments.
  - Latency: 4th-byte strobe in cycle N -> o_imem_wr_en=1 in cycle N+1.
  - Next state:
    - word == HALT_WORD -> DONE.
    - else addr == 2^ADDR_WIDTH-1 -> ERROR.
    - else addr+1 -> COLLECT.
  - A byte strobe arriving during WRITE is accepted as byte 1 of the next word; no byte is lost at back-to-back strobes.
- State DONE: o_done=1, o_busy=0; bytes ignored; i_start -> fresh session (COLLECT, counters cleared, o_done cleared).
- State ERROR: o_error=1, o_busy=0; bytes ignored; i_start -> fresh session (COLLECT, counters cleared, o_error cleared).
- i_start while COLLECT or WRITE: restart. A pending WRITE is still issued in that cycle, then the session restarts at addr 0 with the partial word discarded. i_start has priority over i_rx_valid in the same cycle; that byte is dropped.
- o_busy=1 exactly in COLLECT and WRITE.
- o_imem_wr_addr/o_imem_wr_data hold their last values when o_imem_wr_en=0.
- A HALT word written at the last address gives DONE, not ERROR.

Optional Feature:
- Macro: INSTRUCTION_LOADER_TIMEOUT_EN.
- Defined: a counter runs in COLLECT while 1 <= byte_cnt <= 3. It is cleared on every accepted byte and on leaving COLLECT. Reaching TIMEOUT_CYCLES discards the partial word -> ERROR with no write.
- Not defined: no counter is synthesised, TIMEOUT_CYCLES is unused, and a partial word waits indefinitely.

Test Plan:
- i_start; bytes 24,01,00,05, then FF,FF,FF,FF -> writes addr0=32'h24010005 and addr1=32'hFFFFFFFF, each wr_en one cycle after the 4th byte; o_done=1, o_word_count=2.
- ADDR_WIDTH=2; 4 non-HALT words -> writes at addr 0..3, then o_error=1, o_busy=0; a 5th word produces no write.
- Bytes on consecutive cycles across a word boundary (5th strobe in the WRITE cycle) -> second word assembled correctly, no byte dropped.
- 2 bytes, then i_start, then 8C,22,00,04 -> single write addr0=32'h8C220004; partial bytes discarded.
- i_reset low for 1 cycle after 3 bytes -> all outputs 0, no write; bytes ignored until i_start.
- With INSTRUCTION_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: 1 byte, then 16 idle cycles -> o_error=1, no write. Without the macro, the same stimulus leaves o_busy=1.

Source files
------------

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader
// Brief    : Assembles big-endian bytes from the debug UART into 32-bit
//            instruction words and writes them sequentially into instruction
//            memory from address 0 until a HALT word or memory overflow.
//            Optional inter-byte timeout: define INSTRUCTION_LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_loader #(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_rx_valid,
  output logic                  o_imem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_imem_wr_addr,
  output logic [31:0]           o_imem_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  // A timeout shorter than two cycles would fire before a byte could arrive.
  generate
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("instruction_loader: TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;

`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    accept     = 1'b0;
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    tmo_d      = '0;
`endif

    if (i_start) begin
      // Restart wins over any byte in the same cycle; partial word is dropped.
      state_d    = COLLECT;
      byte_cnt_d = '0;
      word_d     = '0;
      addr_d     = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          accept = i_rx_valid;
        end
        WRITE: begin
          if (word_q == HALT_WORD) begin
            state_d = DONE;
          end else if (addr_q == ADDR_LAST) begin
            state_d = ERROR;
          end else begin
            // A byte arriving during the write starts the next word.
            state_d = COLLECT;
            addr_d  = addr_q + 1'b1;
            accept  = i_rx_valid;
          end
        end
        default: begin
        end
      endcase

      if (accept) begin
        word_d     = {word_q[23:0], i_rx_byte};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          state_d   = WRITE;
          wr_addr_d = addr_q;
          wr_data_d = {word_q[23:0], i_rx_byte};
          count_d   = count_q + 1'b1;
        end
      end

`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
      // Count idle cycles only while a word is partially assembled.
      if (state_q == COLLECT && !accept && byte_cnt_q != 2'd0) begin
        if (tmo_q == TMO_LAST) begin
          state_d    = ERROR;
          byte_cnt_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif
    end

    wr_en_d = (state_d == WRITE);
    busy_d  = (state_d == COLLECT) || (state_d == WRITE);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
  // Inter-byte timeout counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign o_imem_wr_en   = wr_en_q;
  assign o_imem_wr_addr = wr_addr_q;
  assign o_imem_wr_data = wr_data_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_word_count   = count_q;

endmodule
`default_nettype wire
